full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Registered ripple-carry adder computing a + b + c, where c is the carry-in.
- Produces a WIDTH-bit sum and a carry-out.
- At default WIDTH=1 it is the classic single-bit full adder: sum = a^b^c, carry = majority(a,b,c).
- Leaf arithmetic block used inside datapaths; outputs are registered on the one system clock, with a valid qualifier.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, c are valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  input  1  carry-in.
- sum  output  WIDTH  registered sum bits.
- carry  output  1  registered carry-out.
- out_valid  output  1  sum/carry hold the result of an accepted operation.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). No other clock or asynchronous reset.
- Reset: on a rising clk with rst=1, sum=0, carry=0, out_valid=0.
  - rst has priority over in_valid in the same cycle; the operation presented that cycle is dropped.
- Arithmetic: {carry, sum} = a + b + c, computed at WIDTH+1 bits, unsigned.
  - Bit i: s_i = a_i ^ b_i ^ k_i; k_(i+1) = (a_i & b_i) | (a_i & k_i) | (b_i & k_i).
  - k_0 = c; carry = k_WIDTH.
- Latency: exactly 1 cycle.
  - in_valid=1 at edge N -> result on sum/carry and out_valid=1 after edge N.
- Throughput: one operation per cycle; back-to-back in_valid accepted with no bubbles; no backpressure.
- When in_valid=0 at an edge:
  - out_valid goes to 0.
  - sum/carry hold their last values; they are not cleared.
- Wrap-around: all-ones + all-ones + 1 gives sum = all-ones, carry = 1. Overflow is reported only through carry.
- X-free: the combinational path is fully defined for all 0/1 inputs. Inputs are ignored (not sampled) while in_valid=0.
- No internal state beyond the output registers (sum, carry, out_valid).

Decomposition:
- No shared package needed; WIDTH is the only parameter and no typedefs are exported.
- One natural sub-module: fa_cell, a purely combinational 1-bit full adder (a, b, cin -> s, cout).
  - full_adder instantiates WIDTH fa_cell instances in a generate loop, chaining cout to cin.
  - The final cout and the s vector are captured in registers.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, a=1, b=1, c=1 -> sum=0, carry=0, out_valid=0 throughout. First valid op after deassert appears 1 cycle later.
- WIDTH=1 exhaustive truth table: apply (a,b,c) = 000, 001, 010, 011, 100, 101, 110, 111, one per cycle, with in_valid=1 -> (carry,sum) one cycle later = 00, 01, 01, 10, 01, 10, 10, 11; out_valid=1 continuously.
- WIDTH=8 carry ripple: a=0xFF, b=0x00, c=1 -> sum=0x00, carry=1. Then a=0x7F, b=0x01, c=0 -> sum=0x80, carry=0.
- WIDTH=8 max overflow: a=0xFF, b=0xFF, c=1 -> sum=0xFF, carry=1.
- Valid gating: in_valid=1 with a=0x12, b=0x34, c=0, then in_valid=0 with a=0xAA, b=0x55 for 3 cycles -> sum=0x46, carry=0 held; out_valid = 1, then 0, 0, 0.
- Reset mid-stream: back-to-back valid ops, then rst=1 on the cycle an op is presented -> next cycle sum=0, carry=0, out_valid=0; that op produces no result.

Source files
------------

// File: rtl/full_adder_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
// Purely combinational single-bit full adder, the leaf of the ripple chain in
// full_adder.
//
// Ports:
//   a_i     operand A bit
//   b_i     operand B bit
//   cin_i   carry into this bit position
//   s_o     sum bit        = a ^ b ^ cin
//   cout_o  carry out      = majority(a, b, cin)
// -----------------------------------------------------------------------------
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule : fa_cell

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Registered ripple-carry adder: {carry, sum} = a + b + c (unsigned, WIDTH+1
// bits). One result per cycle, one cycle of latency, no backpressure.
//
// Parameters:
//   WIDTH      operand width in bits, 1..64 (WIDTH=1 is the classic full adder)
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous, active-high reset (wins over in_valid)
//   in_valid   a, b, c are valid this cycle
//   a, b       WIDTH-bit operands
//   c          carry-in
//   sum        registered sum bits (held while no new operation arrives)
//   carry      registered carry-out (held while no new operation arrives)
//   out_valid  sum/carry hold the result of the operation accepted last edge
// -----------------------------------------------------------------------------
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("full_adder: WIDTH must be in 1..64");
  end

  // Ripple chain: k[i] is the carry into bit i, k[0] is the carry-in and
  // k[WIDTH] is the final carry-out.
  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] s;

  assign k[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a_i   (a[i]),
      .b_i   (b[i]),
      .cin_i (k[i]),
      .s_o   (s[i]),
      .cout_o(k[i+1])
    );
  end

  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;

  // Operands are only sampled while in_valid is high; otherwise the previous
  // result stays visible and only the valid qualifier drops.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d   = s;
      carry_d = k[WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign out_valid = valid_q;

endmodule : full_adder

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
// Two instances (WIDTH=1 and WIDTH=8) driven by independent stimulus threads.
// Each drive pushes the expected post-edge output state into a queue; a monitor
// per instance pops one entry per clock and compares all outputs.
// -----------------------------------------------------------------------------
module tb_full_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=1 instance
  logic       rst1 = 1'b0, v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic       s1, k1, ov1;
  // WIDTH=8 instance
  logic       rst8 = 1'b0, v8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] s8;
  logic       k8, ov8;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(v1), .a(a1), .b(b1), .c(c1),
    .sum(s1), .carry(k1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(v8), .a(a8), .b(b8), .c(c8),
    .sum(s8), .carry(k8), .out_valid(ov8)
  );

  typedef struct {
    logic       v;
    logic       k;
    logic [7:0] s;
    string      tag;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the architectural output state after each edge, derived
  // from plain integer addition.
  // ---------------------------------------------------------------------------
  logic       m1_v = 1'b0, m1_k = 1'b0, m1_s = 1'b0;
  logic       m8_v = 1'b0, m8_k = 1'b0;
  logic [7:0] m8_s = '0;

  task automatic step1(input string tag, input logic r, input logic v,
                       input logic a, input logic b, input logic c);
    int t;
    exp_t e;
    @(negedge clk);
    rst1 = r; v1 = v; a1 = a; b1 = b; c1 = c;
    if (r) begin
      m1_v = 1'b0; m1_k = 1'b0; m1_s = 1'b0;
    end else if (v) begin
      t = int'(a) + int'(b) + int'(c);
      m1_v = 1'b1; m1_s = t[0]; m1_k = t[1];
    end else begin
      m1_v = 1'b0;
    end
    e.v = m1_v; e.k = m1_k; e.s = {7'd0, m1_s}; e.tag = tag;
    q1.push_back(e);
  endtask

  task automatic step8(input string tag, input logic r, input logic v,
                       input logic [7:0] a, input logic [7:0] b, input logic c);
    int t;
    exp_t e;
    @(negedge clk);
    rst8 = r; v8 = v; a8 = a; b8 = b; c8 = c;
    if (r) begin
      m8_v = 1'b0; m8_k = 1'b0; m8_s = '0;
    end else if (v) begin
      t = int'(a) + int'(b) + int'(c);
      m8_v = 1'b1; m8_s = t[7:0]; m8_k = t[8];
    end else begin
      m8_v = 1'b0;
    end
    e.v = m8_v; e.k = m8_k; e.s = m8_s; e.tag = tag;
    q8.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Monitors: one comparison set per clock per instance with pending entries.
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check({"w1 ", e.tag, " out_valid"}, 64'(ov1), 64'(e.v));
      check({"w1 ", e.tag, " carry"},     64'(k1),  64'(e.k));
      check({"w1 ", e.tag, " sum"},       64'(s1),  64'(e.s[0]));
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q8.size() > 0) begin
      e = q8.pop_front();
      check({"w8 ", e.tag, " out_valid"}, 64'(ov8), 64'(e.v));
      check({"w8 ", e.tag, " carry"},     64'(k8),  64'(e.k));
      check({"w8 ", e.tag, " sum"},       64'(s8),  64'(e.s));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    fork
      begin : w1_thread
        logic [2:0] abc;
        step1("rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step1("rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
          abc = 3'(i);
          step1("truth", 1'b0, 1'b1, abc[2], abc[1], abc[0]);
        end
        step1("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 150; i++) begin
          step1("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                1'($urandom), 1'($urandom), 1'($urandom));
        end
        step1("end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      begin : w8_thread
        step8("rst", 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        step8("rst", 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        step8("first", 1'b0, 1'b1, 8'h03, 8'h04, 1'b1);
        step8("ripple", 1'b0, 1'b1, 8'hFF, 8'h00, 1'b1);
        step8("ripple2", 1'b0, 1'b1, 8'h7F, 8'h01, 1'b0);
        step8("maxovf", 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
        step8("gate_op", 1'b0, 1'b1, 8'h12, 8'h34, 1'b0);
        for (int i = 0; i < 3; i++) step8("gate_hold", 1'b0, 1'b0, 8'hAA, 8'h55, 1'b1);
        step8("b2b", 1'b0, 1'b1, 8'h10, 8'h20, 1'b0);
        step8("b2b", 1'b0, 1'b1, 8'h80, 8'h80, 1'b1);
        step8("midrst", 1'b1, 1'b1, 8'hC3, 8'h5A, 1'b1);
        step8("after_rst", 1'b0, 1'b0, 8'h11, 8'h22, 1'b0);
        step8("post", 1'b0, 1'b1, 8'h01, 8'hFE, 1'b0);
        for (int i = 0; i < 150; i++) begin
          step8("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                8'($urandom), 8'($urandom), 1'($urandom));
        end
        step8("end", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      end
    join

    // Bounded drain: the monitors need one more edge for the last entries.
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (q1.size() != 0 || q8.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d entries left, expected 0/0", q1.size(), q8.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_full_adder
